// File: rtl/univ_reg_cnt_if.sv
// Bundled control, data and status signals of the universal register/counter.
// The controller drives through master; the register/counter itself binds slave.
interface univ_reg_cnt_if #(
  parameter int WIDTH = 4
);
  logic             clear_i;
  logic             en_i;
  logic [2:0]       mode_i;
  logic [WIDTH-1:0] I_i;
  logic             sr_i;
  logic             sl_i;
  logic [WIDTH-1:0] A_o;
  logic             so_o;
  logic             tc_o;

  modport master (
    output clear_i, en_i, mode_i, I_i, sr_i, sl_i,
    input  A_o, so_o, tc_o
  );

  modport slave (
    input  clear_i, en_i, mode_i, I_i, sr_i, sl_i,
    output A_o, so_o, tc_o
  );
endinterface

// File: rtl/univ_reg_cnt.sv
// Universal register/counter: load, shift/rotate both ways, modulo up/down count.
// Synchronous clear beats clock enable, which beats the mode select.
module univ_reg_cnt #(
  parameter int WIDTH   = 4,
  parameter int MOD     = 2**WIDTH,
  parameter int RST_VAL = 0
) (
  input logic           clk_i,
  input logic           rst_ni,
  univ_reg_cnt_if.slave bus
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHR   = 3'b010,
    M_SHL   = 3'b011,
    M_UP    = 3'b100,
    M_DOWN  = 3'b101,
    M_ROR   = 3'b110,
    M_ROL   = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] RST_A   = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  // the modulus can equal 2**WIDTH, so it only fits with one extra bit
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_next;
  logic             at_top;
  logic             at_zero;
  logic             over_mod;
  mode_e            mode;

  assign mode     = mode_e'(bus.mode_i);
  assign at_top   = (a_q >= MAX_VAL);
  assign at_zero  = (a_q == '0);
  assign over_mod = ({1'b0, a_q} >= MOD_EXT);

  always_comb begin
    a_next = a_q;
    if (bus.clear_i) begin
      a_next = RST_A;
    end else if (bus.en_i) begin
      case (mode)
        M_HOLD: a_next = a_q;
        M_LOAD: a_next = bus.I_i;
        M_SHR:  a_next = {bus.sr_i, a_q[WIDTH-1:1]};
        M_SHL:  a_next = {a_q[WIDTH-2:0], bus.sl_i};
        M_UP:   a_next = at_top ? '0 : a_q + 1'b1;
        M_DOWN: begin
          if (at_zero || over_mod) a_next = MAX_VAL;
          else                     a_next = a_q - 1'b1;
        end
        M_ROR:  a_next = {a_q[0], a_q[WIDTH-1:1]};
        M_ROL:  a_next = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        default: a_next = a_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) a_q <= RST_A;
    else         a_q <= a_next;
  end

  always_comb begin
    bus.so_o = 1'b0;
    case (mode)
      M_SHR, M_ROR: bus.so_o = a_q[0];
      M_SHL, M_ROL: bus.so_o = a_q[WIDTH-1];
      default:      bus.so_o = 1'b0;
    endcase
  end

  // High the cycle before a wrap so a following stage can use it as its enable
  assign bus.tc_o = bus.en_i & ~bus.clear_i &
                    (((mode == M_UP) & at_top) | ((mode == M_DOWN) & at_zero));

  assign bus.A_o = a_q;

endmodule

// File: tb/tb_univ_reg_cnt.sv
// Directed bench for univ_reg_cnt: three instances cover WIDTH=4 full modulus,
// WIDTH=4 MOD=10, and WIDTH=8 full modulus.
module tb_univ_reg_cnt;

  logic clk_sys;
  logic rst_n;
  int   checks;
  int   failures;

  univ_reg_cnt_if #(.WIDTH(4)) b4  ();
  univ_reg_cnt_if #(.WIDTH(4)) b10 ();
  univ_reg_cnt_if #(.WIDTH(8)) b8  ();

  univ_reg_cnt #(.WIDTH(4)) u_w4 (
    .clk_i (clk_sys),
    .rst_ni(rst_n),
    .bus   (b4)
  );

  univ_reg_cnt #(.WIDTH(4), .MOD(10)) u_m10 (
    .clk_i (clk_sys),
    .rst_ni(rst_n),
    .bus   (b10)
  );

  univ_reg_cnt #(.WIDTH(8)) u_w8 (
    .clk_i (clk_sys),
    .rst_ni(rst_n),
    .bus   (b8)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    {b4.clear_i,  b4.en_i,  b4.mode_i,  b4.I_i,  b4.sr_i,  b4.sl_i}  = '0;
    {b10.clear_i, b10.en_i, b10.mode_i, b10.I_i, b10.sr_i, b10.sl_i} = '0;
    {b8.clear_i,  b8.en_i,  b8.mode_i,  b8.I_i,  b8.sr_i,  b8.sl_i}  = '0;
    #2;
    chk("reset_a_w4", 32'(b4.A_o), 32'h0);
    chk("reset_a_w8", 32'(b8.A_o), 32'h0);
    #10 rst_n = 1'b1;

    // reset and clear
    b4.en_i = 1'b1; b4.mode_i = 3'b001; b4.I_i = 4'hA;
    step();
    chk("load_a", 32'(b4.A_o), 32'hA);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(b4.A_o), 32'h0);
    #1 rst_n = 1'b1;
    b4.I_i = 4'h5;
    step();
    chk("load_5", 32'(b4.A_o), 32'h5);
    b4.clear_i = 1'b1; b4.I_i = 4'hF;
    step();
    chk("clear_over_load", 32'(b4.A_o), 32'h0);
    b4.clear_i = 1'b0;

    // load sweep and hold
    for (int i = 15; i >= 0; i--) begin
      b4.I_i = 4'(i);
      step();
      chk("load_sweep", 32'(b4.A_o), 32'(i));
    end
    b4.en_i = 1'b0; b4.I_i = 4'h3;
    step();
    chk("hold_en_low", 32'(b4.A_o), 32'h0);
    b4.mode_i = 3'bxxx;
    step();
    chk("hold_x_mode", 32'(b4.A_o), 32'h0);
    b4.mode_i = 3'b001;

    // shift and rotate
    b4.en_i = 1'b1; b4.I_i = 4'b1001;
    step();
    chk("load_1001", 32'(b4.A_o), 32'h9);
    b4.mode_i = 3'b010; b4.sr_i = 1'b0;
    #1 chk("so_shr", 32'(b4.so_o), 32'h1);
    step();
    chk("shr", 32'(b4.A_o), 32'h4);
    b4.mode_i = 3'b011; b4.sl_i = 1'b1;
    #1 chk("so_shl", 32'(b4.so_o), 32'h0);
    step();
    chk("shl", 32'(b4.A_o), 32'h9);
    b4.mode_i = 3'b110;
    #1 chk("so_ror", 32'(b4.so_o), 32'h1);
    step();
    chk("ror", 32'(b4.A_o), 32'hC);
    b4.mode_i = 3'b111;
    #1 chk("so_rol", 32'(b4.so_o), 32'h1);
    step();
    chk("rol_1", 32'(b4.A_o), 32'h9);
    step();
    chk("rol_2", 32'(b4.A_o), 32'h3);
    b4.mode_i = 3'b100;
    #1 chk("so_count_mode", 32'(b4.so_o), 32'h0);

    // modulo-10 count up
    b10.en_i = 1'b1; b10.mode_i = 3'b001; b10.I_i = 4'h0;
    step();
    b10.mode_i = 3'b100;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("up_value", 32'(b10.A_o), 32'(i));
      chk("up_tc", 32'(b10.tc_o), (i == 9) ? 32'h1 : 32'h0);
      step();
    end
    chk("up_wrap", 32'(b10.A_o), 32'h0);
    b10.mode_i = 3'b001; b10.I_i = 4'hC;
    step();
    b10.mode_i = 3'b100;
    #1 chk("up_tc_over_mod", 32'(b10.tc_o), 32'h1);
    step();
    chk("up_from_over_mod", 32'(b10.A_o), 32'h0);

    // modulo-10 count down
    b10.mode_i = 3'b001; b10.I_i = 4'h1;
    step();
    b10.mode_i = 3'b101;
    #1 chk("down_tc_at_1", 32'(b10.tc_o), 32'h0);
    step();
    chk("down_to_0", 32'(b10.A_o), 32'h0);
    chk("down_tc_at_0", 32'(b10.tc_o), 32'h1);
    step();
    chk("down_wrap", 32'(b10.A_o), 32'h9);
    b10.mode_i = 3'b001; b10.I_i = 4'hE;
    step();
    b10.mode_i = 3'b101;
    #1 chk("down_tc_over_mod", 32'(b10.tc_o), 32'h0);
    step();
    chk("down_from_over_mod", 32'(b10.A_o), 32'h9);

    // 8-bit full-range cascade corner
    b8.en_i = 1'b1; b8.mode_i = 3'b001; b8.I_i = 8'hFE;
    step();
    b8.mode_i = 3'b100;
    #1 chk("w8_tc_fe", 32'(b8.tc_o), 32'h0);
    step();
    chk("w8_ff", 32'(b8.A_o), 32'hFF);
    chk("w8_tc_ff", 32'(b8.tc_o), 32'h1);
    b8.en_i = 1'b0;
    #1 chk("w8_tc_en_low", 32'(b8.tc_o), 32'h0);
    step();
    chk("w8_hold_ff", 32'(b8.A_o), 32'hFF);
    b8.en_i = 1'b1; b8.clear_i = 1'b1;
    #1 chk("w8_tc_clear", 32'(b8.tc_o), 32'h0);
    b8.clear_i = 1'b0;
    step();
    chk("w8_wrap", 32'(b8.A_o), 32'h00);
    b8.mode_i = 3'b001; b8.I_i = 8'h5A;
    step();
    b8.en_i = 1'b0; b8.clear_i = 1'b1;
    step();
    chk("w8_clear_en_low", 32'(b8.A_o), 32'h00);
    b8.clear_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_reg_cnt.md
Name: univ_reg_cnt

Overview:
Parametrised universal register/counter, the successor to the fixed 4-bit load/clear register. It adds configurable width, parallel load, shift and rotate in both directions, and modulo up/down counting, with synchronous clear and a clock enable. It is the general storage/sequencing element for later datapath exercises such as shift-and-add, serial transfer and timers.

Parameters:
WIDTH, 4, register width in bits (>=2)
MOD, 2**WIDTH, counter modulus; count modes wrap within 0..MOD-1 (2 <= MOD <= 2**WIDTH)
RST_VAL, 0, value loaded on async reset and on sync clear (must be < MOD)

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_ni  input  1  asynchronous, active-low reset
clear_i  input  1  synchronous clear to RST_VAL; highest synchronous priority
en_i  input  1  clock enable; when low, hold (clear_i still acts)
mode_i  input  3  operation select (see Behaviour)
I_i  input  WIDTH  parallel load data
sr_i  input  1  serial in for shift right (enters MSB)
sl_i  input  1  serial in for shift left (enters LSB)
A_o  output  WIDTH  register contents
so_o  output  1  serial out: the bit shifted out this cycle (comb)
tc_o  output  1  terminal count (comb)

Behaviour:
- Reset: rst_ni=0 forces A_o=RST_VAL immediately, with no clock needed. This overrides everything else.
- Release of rst_ni is synchronous to the design. The first active edge after release performs the normal operation.
- Per rising edge, the priority order is: clear_i=1 -> A=RST_VAL; else en_i=0 -> hold; else act on mode_i.
- mode_i 000 hold: A unchanged.
- mode_i 001 load: A <= I_i. If I_i >= MOD, the value loads unmodified. Count modes then behave as below.
- mode_i 010 shift right: A <= {sr_i, A[WIDTH-1:1]}.
- mode_i 011 shift left: A <= {A[WIDTH-2:0], sl_i}.
- mode_i 100 count up: if A >= MOD-1 then A <= 0, else A <= A+1.
- mode_i 101 count down: if A == 0 then A <= MOD-1, else if A >= MOD then A <= MOD-1, else A <= A-1.
- mode_i 110 rotate right: A <= {A[0], A[WIDTH-1:1]}.
- mode_i 111 rotate left: A <= {A[WIDTH-2:0], A[WIDTH-1]}.
- Latency: one clock from input to A_o. A_o is driven directly from the state register (no output logic).
- so_o is combinational from current A and mode_i:
  - modes 010/110: A[0]
  - modes 011/111: A[WIDTH-1]
  - all other modes: 0
  - so_o is valid regardless of en_i.
- tc_o = en_i & ~clear_i & ((mode_i==100 & A>=MOD-1) | (mode_i==101 & A==0)). It is high in the cycle before a wrap, so counters can be cascaded through en_i.
- Arithmetic is unsigned, modulo within WIDTH. No intermediate value may exceed WIDTH+1 bits.
- When clear_i and rst_ni are both active, reset wins. When clear_i and any mode are active, clear wins.
- An undefined (X) mode_i must not corrupt A when en_i=0.

Test Plan:
1. Reset and clear, WIDTH=4, RST_VAL=0: load 4'hA, then assert rst_ni=0 between clock edges -> A_o=0 immediately. Then load 4'h5 and pulse clear_i with mode_i=001, I_i=4'hF -> A_o=0 after the edge.
2. Load and hold, WIDTH=4: sweep I_i from 4'hF down to 4'h0, one value per cycle, with mode 001 -> A_o tracks I_i one cycle later. Then en_i=0 with mode 001 and I_i=4'h3 -> A_o stays 0.
3. Shift and rotate, WIDTH=4: A=4'b1001.
   - Shift right, sr_i=0 -> A=4'b0100, so_o was 1.
   - Shift left, sl_i=1 -> A=4'b1001.
   - Rotate right -> A=4'b1100.
   - Rotate left twice -> A=4'b0011.
4. Modulo count up, WIDTH=4, MOD=10: count up from 0.
   - A goes 0..9, tc_o=1 only at A=9, then wraps to 0.
   - Load 4'hC, count up -> A=0 next cycle.
5. Count down, WIDTH=4, MOD=10: start at A=1 -> A=0 (tc_o=1), then A=9. Load 4'hE, count down -> A=9.
6. Cascade and corner cases, WIDTH=8 with default MOD: count up from 8'hFE -> FF (tc_o=1) -> 00. With en_i=0 at A=FF in count-up mode -> tc_o=0 and A holds.
